// File: rtl/processor_step_tracer.sv
// Debug step controller: gates the core clock-enable in halt/step/run-N/free-run mode
// and records ALU/MEM results with a cycle tag into a small trace FIFO.
`timescale 1ns/1ps

module processor_step_tracer #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16,
  parameter int DEPTH  = 8,
  parameter int WRAP   = 0
) (
  input  logic                     Clk,
  input  logic                     Reset_n,
  input  logic [1:0]               Mode,
  input  logic                     Start,
  input  logic                     Stop,
  input  logic [CNT_W-1:0]         Step_Count,
  input  logic [DATA_W-1:0]        ALU_Out,
  input  logic [DATA_W-1:0]        MEM_Out,
  input  logic                     Trace_Rd,
  output logic                     Cpu_En,
  output logic                     Busy,
  output logic                     Done,
  output logic [DATA_W-1:0]        Trace_Alu,
  output logic [DATA_W-1:0]        Trace_Mem,
  output logic [CNT_W-1:0]         Trace_Cycle,
  output logic                     Trace_Valid,
  output logic [$clog2(DEPTH):0]   Trace_Level,
  output logic                     Overflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam logic [LVL_W-1:0] FULL_LEVEL = LVL_W'(DEPTH);
  localparam bit WRAP_EN = (WRAP != 0);

  typedef enum logic [1:0] {IDLE, RUN, CAPTURE_LAST} state_t;
  typedef enum logic [1:0] {MODE_HALT, MODE_STEP, MODE_RUN_N, MODE_FREE} mode_t;

  typedef struct packed {
    logic [DATA_W-1:0] alu;
    logic [DATA_W-1:0] mem;
    logic [CNT_W-1:0]  tag;
  } entry_t;

  state_t           state;
  logic [CNT_W-1:0] remaining;
  logic             free_run;

  logic             cap_pending;
  logic [CNT_W-1:0] tag_cnt;

  entry_t           mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  entry_t           head;
  logic             push;
  logic             pop;
  logic             full;
  logic             write_en;
  logic             rd_adv;

  // NOTE: all state is updated with non-blocking assignments so every flop
  // samples the pre-edge values of its neighbours, independent of block order.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state     <= IDLE;
      remaining <= '0;
      free_run  <= 1'b0;
      Cpu_En    <= 1'b0;
      Busy      <= 1'b0;
      Done      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          Done <= 1'b0;
          if (Start) begin
            case (mode_t'(Mode))
              MODE_HALT: Done <= 1'b1;
              MODE_STEP: begin
                remaining <= CNT_W'(1);
                free_run  <= 1'b0;
              end
              MODE_RUN_N: begin
                remaining <= (Step_Count == '0) ? CNT_W'(1) : Step_Count;
                free_run  <= 1'b0;
              end
              MODE_FREE: free_run <= 1'b1;
            endcase
            if (mode_t'(Mode) != MODE_HALT) begin
              state  <= RUN;
              Cpu_En <= 1'b1;
              Busy   <= 1'b1;
            end
          end
        end
        RUN: begin
          // The current cycle is already enabled, so Stop and last count end identically.
          if ((!free_run && remaining == CNT_W'(1)) || Stop) begin
            state  <= CAPTURE_LAST;
            Cpu_En <= 1'b0;
            Done   <= 1'b1;
          end else if (!free_run) begin
            remaining <= remaining - CNT_W'(1);
          end
        end
        CAPTURE_LAST: begin
          state <= IDLE;
          Busy  <= 1'b0;
          Done  <= 1'b0;
        end
        default: begin
          state  <= IDLE;
          Cpu_En <= 1'b0;
          Busy   <= 1'b0;
          Done   <= 1'b0;
        end
      endcase
    end
  end

  // Core results of an enabled cycle appear one cycle later.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) cap_pending <= 1'b0;
    else          cap_pending <= Cpu_En;
  end

  assign push     = cap_pending;
  assign pop      = Trace_Rd && Trace_Valid;
  assign full     = (Trace_Level == FULL_LEVEL);
  assign write_en = push && (!full || pop || WRAP_EN);
  assign rd_adv   = pop || (push && full && WRAP_EN);

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      Trace_Level <= '0;
      tag_cnt     <= '0;
      Overflow    <= 1'b0;
    end else begin
      if (write_en) wr_ptr <= wr_ptr + PTR_W'(1);
      if (rd_adv)   rd_ptr <= rd_ptr + PTR_W'(1);
      Trace_Level <= Trace_Level + LVL_W'(write_en) - LVL_W'(rd_adv);
      // Every capture consumes a tag, even one dropped on overflow.
      if (push) tag_cnt <= tag_cnt + CNT_W'(1);
      if (push && full && !pop) Overflow <= 1'b1;
    end
  end

  // NOTE: the storage array has no reset; emptiness is tracked by the level
  // counter, and the head outputs are masked while nothing is stored.
  always_ff @(posedge Clk) begin
    if (write_en) mem[wr_ptr] <= {ALU_Out, MEM_Out, tag_cnt};
  end

  assign head        = mem[rd_ptr];
  assign Trace_Valid = (Trace_Level != '0);
  assign Trace_Alu   = Trace_Valid ? head.alu : '0;
  assign Trace_Mem   = Trace_Valid ? head.mem : '0;
  assign Trace_Cycle = Trace_Valid ? head.tag : '0;

endmodule

// File: tb/tb_processor_step_tracer.sv
// Bench for processor_step_tracer: WRAP=0 and WRAP=1 instances share stimulus and are
// compared every cycle against a queue-based reference model, plus literal checkpoints.
`timescale 1ns/1ps

module tb_processor_step_tracer;

  localparam int DEPTH = 8;

  typedef struct packed {
    logic [31:0] alu;
    logic [31:0] mem;
    logic [15:0] tag;
  } entry_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  mode = 2'd0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic [15:0] step_count = 16'd0;
  logic [31:0] alu_out = 32'd0;
  logic [31:0] mem_out = 32'd0;
  logic        trace_rd = 1'b0;

  logic        cpu_en [2];
  logic        busy [2];
  logic        done [2];
  logic [31:0] t_alu [2];
  logic [31:0] t_mem [2];
  logic [15:0] t_cycle [2];
  logic        t_valid [2];
  logic [3:0]  t_level [2];
  logic        ovf [2];

  int vectors = 0;
  int miscompares = 0;
  bit cmp_on = 1'b0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    processor_step_tracer #(
      .DATA_W(32), .CNT_W(16), .DEPTH(DEPTH), .WRAP(g)
    ) dut (
      .Clk(clk),
      .Reset_n(reset_n),
      .Mode(mode),
      .Start(start),
      .Stop(stop),
      .Step_Count(step_count),
      .ALU_Out(alu_out),
      .MEM_Out(mem_out),
      .Trace_Rd(trace_rd),
      .Cpu_En(cpu_en[g]),
      .Busy(busy[g]),
      .Done(done[g]),
      .Trace_Alu(t_alu[g]),
      .Trace_Mem(t_mem[g]),
      .Trace_Cycle(t_cycle[g]),
      .Trace_Valid(t_valid[g]),
      .Trace_Level(t_level[g]),
      .Overflow(ovf[g])
    );
  end

  // ---------------- reference model ----------------
  entry_t q0[$];
  entry_t q1[$];
  bit     m_en, m_busy, m_done, cap_due;
  bit     m_ovf [2];
  int     left, tag;

  task automatic model_reset();
    q0.delete();
    q1.delete();
    m_en = 0; m_busy = 0; m_done = 0; cap_due = 0;
    m_ovf[0] = 0; m_ovf[1] = 0;
    left = 0; tag = 0;
  endtask

  task automatic model_step();
    entry_t e;
    e = {alu_out, mem_out, tag[15:0]};
    if (trace_rd && q0.size() > 0) void'(q0.pop_front());
    if (trace_rd && q1.size() > 0) void'(q1.pop_front());
    if (cap_due) begin
      if (q0.size() < DEPTH) q0.push_back(e);
      else m_ovf[0] = 1;
      if (q1.size() < DEPTH) q1.push_back(e);
      else begin
        m_ovf[1] = 1;
        void'(q1.pop_front());
        q1.push_back(e);
      end
      tag = (tag + 1) % 65536;
    end
    cap_due = m_en;
    if (m_en) begin
      if (left == 1 || stop) begin
        m_en = 0;
        m_done = 1;
      end else if (left > 0) left--;
    end else if (m_busy) begin
      m_busy = 0;
      m_done = 0;
    end else begin
      m_done = 0;
      if (start) begin
        case (mode)
          2'd0: m_done = 1;
          2'd1: left = 1;
          2'd2: left = (step_count == 0) ? 1 : int'(step_count);
          default: left = -1;
        endcase
        if (mode != 2'd0) begin
          m_en = 1;
          m_busy = 1;
        end
      end
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge reset_n);
      if (!reset_n) model_reset();
      else model_step();
    end
  end

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic compare_all();
    for (int g = 0; g < 2; g++) begin
      int sz;
      entry_t h;
      sz = (g == 0) ? q0.size() : q1.size();
      h = '0;
      if (sz > 0) h = (g == 0) ? q0[0] : q1[0];
      check($sformatf("cpu_en[%0d]", g), 64'(cpu_en[g]), 64'(m_en));
      check($sformatf("busy[%0d]", g), 64'(busy[g]), 64'(m_busy));
      check($sformatf("done[%0d]", g), 64'(done[g]), 64'(m_done));
      check($sformatf("level[%0d]", g), 64'(t_level[g]), 64'(sz));
      check($sformatf("valid[%0d]", g), 64'(t_valid[g]), 64'(sz != 0));
      check($sformatf("overflow[%0d]", g), 64'(ovf[g]), 64'(m_ovf[g]));
      if (sz > 0) begin
        check($sformatf("head_alu[%0d]", g), 64'(t_alu[g]), 64'(h.alu));
        check($sformatf("head_mem[%0d]", g), 64'(t_mem[g]), 64'(h.mem));
        check($sformatf("head_tag[%0d]", g), 64'(t_cycle[g]), 64'(h.tag));
      end
    end
  endtask

  initial forever begin
    @(negedge clk);
    if (cmp_on) compare_all();
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    reset_n = 0;
    start = 0; stop = 0; trace_rd = 0;
    tick();
    tick();
    reset_n = 1;
  endtask

  task automatic do_start(input logic [1:0] m, input logic [15:0] n);
    start = 1; mode = m; step_count = n;
    tick();
    start = 0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!busy[0] && !busy[1]) return;
    end
    check("wait_idle_timeout", 64'd1, 64'd0);
  endtask

  initial begin
    reset_dut();
    cmp_on = 1;

    // single step
    alu_out = 32'h5; mem_out = 32'hA5;
    do_start(2'd1, 16'd0);
    @(negedge clk); check("step_en", 64'(cpu_en[0]), 64'd1);
    tick(); @(negedge clk);
    check("step_done", 64'(done[0]), 64'd1);
    check("step_en_off", 64'(cpu_en[0]), 64'd0);
    tick(); @(negedge clk);
    check("step_level", 64'(t_level[0]), 64'd1);
    check("step_alu", 64'(t_alu[0]), 64'h5);
    check("step_tag", 64'(t_cycle[0]), 64'd0);
    check("step_busy", 64'(busy[0]), 64'd0);

    // halt: Done only
    do_start(2'd0, 16'd0);
    @(negedge clk);
    check("halt_done", 64'(done[1]), 64'd1);
    check("halt_busy", 64'(busy[1]), 64'd0);

    // run-N of 3
    reset_dut();
    do_start(2'd2, 16'd3);
    alu_out = 32'd0; tick();
    alu_out = 32'd1; tick();
    alu_out = 32'd2; tick();
    alu_out = 32'd3;
    @(negedge clk); check("run3_done", 64'(done[0]), 64'd1);
    tick(); @(negedge clk);
    check("run3_level", 64'(t_level[0]), 64'd3);
    check("run3_head_alu", 64'(t_alu[0]), 64'd1);
    check("run3_head_tag", 64'(t_cycle[0]), 64'd0);
    trace_rd = 1; tick(); tick(); trace_rd = 0;
    @(negedge clk);
    check("run3_last_alu", 64'(t_alu[0]), 64'd3);
    check("run3_last_tag", 64'(t_cycle[0]), 64'd2);

    // free-run stopped during the 4th enable
    reset_dut();
    do_start(2'd3, 16'd0);
    tick(); tick(); tick();
    stop = 1; tick(); stop = 0;
    @(negedge clk);
    check("free_done", 64'(done[0]), 64'd1);
    tick(); @(negedge clk);
    check("free_busy", 64'(busy[0]), 64'd0);
    check("free_level", 64'(t_level[0]), 64'd4);

    // run-N 10 into an 8-deep FIFO
    reset_dut();
    do_start(2'd2, 16'd10);
    wait_idle();
    check("drop_level", 64'(t_level[0]), 64'd8);
    check("drop_tag", 64'(t_cycle[0]), 64'd0);
    check("drop_ovf", 64'(ovf[0]), 64'd1);
    check("wrap_level", 64'(t_level[1]), 64'd8);
    check("wrap_tag", 64'(t_cycle[1]), 64'd2);
    check("wrap_ovf", 64'(ovf[1]), 64'd1);

    // full FIFO: read and push in the same cycle
    reset_dut();
    do_start(2'd2, 16'd8);
    wait_idle();
    check("fill_level", 64'(t_level[0]), 64'd8);
    check("fill_ovf", 64'(ovf[0]), 64'd0);
    do_start(2'd1, 16'd0);
    tick();
    trace_rd = 1; tick(); trace_rd = 0;
    @(negedge clk);
    for (int g = 0; g < 2; g++) begin
      check($sformatf("rdpush_level[%0d]", g), 64'(t_level[g]), 64'd8);
      check($sformatf("rdpush_ovf[%0d]", g), 64'(ovf[g]), 64'd0);
      check($sformatf("rdpush_tag[%0d]", g), 64'(t_cycle[g]), 64'd1);
    end

    // reset in the middle of a run
    reset_dut();
    do_start(2'd2, 16'd10);
    tick(); tick();
    #2 reset_n = 0;
    #1;
    for (int g = 0; g < 2; g++) begin
      check($sformatf("midrst_en[%0d]", g), 64'(cpu_en[g]), 64'd0);
      check($sformatf("midrst_busy[%0d]", g), 64'(busy[g]), 64'd0);
      check($sformatf("midrst_valid[%0d]", g), 64'(t_valid[g]), 64'd0);
    end
    @(posedge clk); #1 reset_n = 1;
    do_start(2'd1, 16'd0);
    wait_idle();
    check("midrst_after_level", 64'(t_level[0]), 64'd1);
    check("midrst_after_tag", 64'(t_cycle[0]), 64'd0);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      start      = ($urandom_range(0, 5) == 0);
      mode       = 2'($urandom_range(0, 3));
      step_count = 16'($urandom_range(0, 12));
      stop       = ($urandom_range(0, 9) == 0);
      trace_rd   = (i < 1500) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 2) != 0);
      alu_out    = $urandom;
      mem_out    = $urandom;
      if ($urandom_range(0, 799) == 0) reset_dut();
      else tick();
    end
    start = 0; stop = 0; trace_rd = 0;
    tick(); tick();
    @(negedge clk);
    #1;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
